// File: rtl/writeback_if.sv
// Memory-to-writeback stage bus: instruction, load data, ALU result, PC
// and the valid/ready handshake between the two stages.
interface writeback_if #(
    parameter int XLEN = 32
);
    logic [31:0]     IR;     // instruction from memory stage
    logic [XLEN-1:0] RD;     // raw load data, low bytes valid
    logic [XLEN-1:0] A;      // ALU result / effective address
    logic [XLEN-1:0] PC;     // instruction PC
    logic            v_in;   // memory stage has a valid instruction
    logic            r_out;  // writeback can take it

    // Memory stage side: drives the payload and valid, observes ready.
    modport master (
        output IR, RD, A, PC, v_in,
        input  r_out
    );

    // Writeback side: consumes the payload and valid, drives ready.
    modport slave (
        input  IR, RD, A, PC, v_in,
        output r_out
    );
endinterface

// File: rtl/writeback.sv
// Writeback stage: final pipeline stage after memory.
// Extends load data, selects the write-back value, owns the integer
// register file (two combinational read ports, one write port) and
// publishes the in-flight write for forwarding.
// Optional feature macro: WB_RETIRE_CNT_EN builds a 64-bit retired
// instruction counter; without it, retired is tied to zero.
module writeback #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    writeback_if.slave               bus,
    input  logic                     stall,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [$clog2(NREGS)-1:0] fwd_rd,
    output logic [XLEN-1:0]          fwd_data,
    output logic [63:0]              retired
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    // Stage registers
    logic            r_q;
    logic            valid_q;
    logic            we_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] pc_q;

    // Register file; x0 is never stored, reads of it are forced to zero.
    logic [XLEN-1:0] regs [1:NREGS-1];

    logic            accept;
    logic            commit;
    logic            we_d;
    logic [XLEN-1:0] wdata_d;

    assign bus.r_out = r_q;
    assign accept    = bus.v_in & r_q;
    // A write is pending only when it targets a real register.
    assign commit    = valid_q & we_q & (rd_q != '0);

    // Decode the opcode into a write enable and the extended write value.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a
        // missing branch would otherwise infer a latch.
        we_d    = 1'b0;
        wdata_d = '0;
        case (bus.IR[6:0])
            OP_LOAD: begin
                case (bus.IR[14:12])
                    3'd0: begin
                        we_d    = 1'b1;
                        wdata_d = {{(XLEN-8){bus.RD[7]}}, bus.RD[7:0]};
                    end
                    3'd1: begin
                        we_d    = 1'b1;
                        wdata_d = {{(XLEN-16){bus.RD[15]}}, bus.RD[15:0]};
                    end
                    3'd2: begin
                        we_d    = 1'b1;
                        wdata_d = bus.RD;
                    end
                    3'd4: begin
                        we_d    = 1'b1;
                        wdata_d = {{(XLEN-8){1'b0}}, bus.RD[7:0]};
                    end
                    3'd5: begin
                        we_d    = 1'b1;
                        wdata_d = {{(XLEN-16){1'b0}}, bus.RD[15:0]};
                    end
                    default: ;  // reserved widths: no write
                endcase
            end
            OP_JAL, OP_JALR: begin
                // Link address wraps naturally at the top of the address space.
                we_d    = 1'b1;
                wdata_d = bus.PC + XLEN'(4);
            end
            OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM: begin
                we_d    = 1'b1;
                wdata_d = bus.A;
            end
            default: ;  // stores, branches, system and unknown: no write
        endcase
    end

    // Handshake and stage capture; ready simply follows the inverse of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= 1'b1;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_q <= ~stall;
            if (accept) begin
                valid_q <= 1'b1;
                we_q    <= we_d;
                rd_q    <= bus.IR[7 +: AW];
                wdata_q <= wdata_d;
                pc_q    <= bus.PC;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // Register file write, one edge after capture; reset clears x1..x31.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is reset on purpose, so it maps to flops rather
            // than a RAM macro; an unreset array would read X after reset.
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[rd_q] <= wdata_q;
        end
    end

    // Forwarding view of the pending write; zero rd means nothing pending.
    assign fwd_rd   = commit ? rd_q : '0;
    assign fwd_data = wdata_q;

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (commit && (addr == rd_q)) begin
            return wdata_q;
        end else begin
            return regs[addr];
        end
    endfunction

    // Combinational read ports with same-cycle bypass of the pending write.
    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_q;

    // Count every instruction leaving the stage, including non-writing ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (valid_q) begin
            retired_q <= retired_q + 64'd1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 64'd0;
`endif

    // Captured PC and upper instruction bits are kept for observability only.
    logic unused_ok;
    assign unused_ok = ^{pc_q, bus.IR[31:15]};
endmodule

// File: tb/tb_writeback.sv
// Directed testbench for the writeback stage: a vector table of single
// instructions plus hand-written sequences for reset, back-to-back
// accepts, stall and the retired counter (WB_RETIRE_CNT_EN).
module tb_writeback;
    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] pc;
        logic        we;   // expected: instruction writes a register
        logic [31:0] val;  // expected write value (when we)
    } vec_t;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] OPR   = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BRNCH = 7'b1100011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] retired;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] model [32];
    vec_t        vecs [19];

    writeback_if #(.XLEN(32)) bus ();

    writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .stall    (stall),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, op};
    endfunction

    function automatic vec_t mkv(input string n, input logic [31:0] ir, input logic [31:0] rd,
                                 input logic [31:0] a, input logic [31:0] pc,
                                 input logic we, input logic [31:0] val);
        vec_t v;
        v.name = n; v.ir = ir; v.rd = rd; v.a = a; v.pc = pc; v.we = we; v.val = val;
        return v;
    endfunction

    // Present one instruction for a single accept edge, then drop valid.
    task automatic send(input logic [31:0] ir, input logic [31:0] rd, input logic [31:0] a, input logic [31:0] pc);
        @(negedge clk);
        bus.IR = ir; bus.RD = rd; bus.A = a; bus.PC = pc; bus.v_in = 1'b1;
        @(posedge clk);
        #1;
        bus.v_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read1(input logic [4:0] addr);
        rs1_addr = addr;
        #1;
    endtask

    initial begin
        logic [4:0]  rdf;
        logic [4:0]  exp_fwd;
        logic [31:0] exp_rd;
        logic [63:0] exp_ret;

        bus.IR = '0; bus.RD = '0; bus.A = '0; bus.PC = '0; bus.v_in = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        vecs[0]  = mkv("lb_neg",    enc(LOAD, 3'd0, 5'd3),  32'h0000_00F0, JUNK, JUNK, 1'b1, 32'hFFFF_FFF0);
        vecs[1]  = mkv("lbu",       enc(LOAD, 3'd4, 5'd3),  32'h0000_00F0, JUNK, JUNK, 1'b1, 32'h0000_00F0);
        vecs[2]  = mkv("lh_neg",    enc(LOAD, 3'd1, 5'd4),  32'h0000_8001, JUNK, JUNK, 1'b1, 32'hFFFF_8001);
        vecs[3]  = mkv("lhu",       enc(LOAD, 3'd5, 5'd4),  32'hABCD_8001, JUNK, JUNK, 1'b1, 32'h0000_8001);
        vecs[4]  = mkv("lw",        enc(LOAD, 3'd2, 5'd5),  32'h1234_5678, JUNK, JUNK, 1'b1, 32'h1234_5678);
        vecs[5]  = mkv("lb_pos",    enc(LOAD, 3'd0, 5'd12), 32'hFFFF_FF7F, JUNK, JUNK, 1'b1, 32'h0000_007F);
        vecs[6]  = mkv("jal",       enc(JAL,  3'd0, 5'd1),  JUNK, JUNK, 32'h0000_0100, 1'b1, 32'h0000_0104);
        vecs[7]  = mkv("jal_wrap",  enc(JAL,  3'd0, 5'd1),  JUNK, JUNK, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000);
        vecs[8]  = mkv("jalr",      enc(JALR, 3'd0, 5'd2),  JUNK, JUNK, 32'h0000_0200, 1'b1, 32'h0000_0204);
        vecs[9]  = mkv("addi",      enc(OPI,  3'd0, 5'd7),  JUNK, 32'h0000_0055, JUNK, 1'b1, 32'h0000_0055);
        vecs[10] = mkv("lui",       enc(LUI,  3'd0, 5'd8),  JUNK, 32'hABCD_E000, JUNK, 1'b1, 32'hABCD_E000);
        vecs[11] = mkv("op",        enc(OPR,  3'd0, 5'd9),  JUNK, 32'hDEAD_BEEF, JUNK, 1'b1, 32'hDEAD_BEEF);
        vecs[12] = mkv("auipc",     enc(AUIPC,3'd0, 5'd10), JUNK, 32'h0000_1000, JUNK, 1'b1, 32'h0000_1000);
        vecs[13] = mkv("store",     enc(STORE,3'd2, 5'd7),  JUNK, 32'h0000_0011, JUNK, 1'b0, 32'h0);
        vecs[14] = mkv("branch",    enc(BRNCH,3'd0, 5'd9),  JUNK, 32'h0000_0022, JUNK, 1'b0, 32'h0);
        vecs[15] = mkv("addi_x0",   enc(OPI,  3'd0, 5'd0),  JUNK, 32'h0000_0077, JUNK, 1'b0, 32'h0);
        vecs[16] = mkv("load_f3_3", enc(LOAD, 3'd3, 5'd3),  32'h5555_5555, JUNK, JUNK, 1'b0, 32'h0);
        vecs[17] = mkv("load_f3_6", enc(LOAD, 3'd6, 5'd3),  32'h5555_5555, JUNK, JUNK, 1'b0, 32'h0);
        vecs[18] = mkv("system",    enc(SYS,  3'd0, 5'd11), JUNK, 32'h0000_0033, JUNK, 1'b0, 32'h0);

        // ---- Reset: force r_out low first so the reset value is visible.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b1;
        tick();
        check("stall_drops_ready", bus.r_out, 1'b0);
        #2;
        rst_n = 1'b0;
        read1(5'd5);
        check("reset_r_out", bus.r_out, 1'b1);
        check("reset_fwd_rd", fwd_rd, 5'd0);
        check("reset_rs1_x5", rs1_data, 32'd0);
        check("reset_retired", retired, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;

        // ---- Table: one instruction each, bypass view then committed view.
        for (int i = 0; i < 19; i++) begin
            rdf     = vecs[i].ir[11:7];
            exp_fwd = (vecs[i].we && rdf != 5'd0) ? rdf : 5'd0;
            exp_rd  = (exp_fwd != 5'd0) ? vecs[i].val : model[rdf];
            send(vecs[i].ir, vecs[i].rd, vecs[i].a, vecs[i].pc);
            rs1_addr = rdf;
            rs2_addr = rdf;
            #1;
            check({vecs[i].name, "_fwd_rd"}, fwd_rd, exp_fwd);
            if (exp_fwd != 5'd0) check({vecs[i].name, "_fwd_data"}, fwd_data, vecs[i].val);
            check({vecs[i].name, "_bypass_rs1"}, rs1_data, exp_rd);
            check({vecs[i].name, "_bypass_rs2"}, rs2_data, exp_rd);
            if (exp_fwd != 5'd0) model[rdf] = vecs[i].val;
            tick();
            read1(rdf);
            check({vecs[i].name, "_committed"}, rs1_data, model[rdf]);
            check({vecs[i].name, "_fwd_idle"}, fwd_rd, 5'd0);
        end

        // ---- Back-to-back accepts to x13: later value wins.
        @(negedge clk);
        bus.IR = enc(OPI, 3'd0, 5'd13); bus.A = 32'h0000_0001; bus.v_in = 1'b1;
        @(posedge clk);
        #1;
        bus.A = 32'h0000_0002;
        read1(5'd13);
        check("b2b_first_fwd", fwd_data, 32'h1);
        @(posedge clk);
        #1;
        bus.v_in = 1'b0;
        rs1_addr = 5'd13;
        rs2_addr = 5'd7;
        #1;
        check("b2b_second_fwd_rd", fwd_rd, 5'd13);
        check("b2b_second_bypass", rs1_data, 32'h2);
        check("b2b_other_port", rs2_data, 32'h55);
        tick();
        read1(5'd13);
        check("b2b_final", rs1_data, 32'h2);

        // ---- Stall coincident with accept.
        @(negedge clk);
        bus.IR = enc(OPI, 3'd0, 5'd14); bus.A = 32'h0000_0065; bus.v_in = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        bus.A = 32'h0000_0066;  // next instruction held while stalled
        check("stall_accept_fwd_rd", fwd_rd, 5'd14);
        check("stall_accept_data", fwd_data, 32'h65);
        check("stall_r_out_low", bus.r_out, 1'b0);
        tick();
        read1(5'd14);
        check("stall_no_accept", fwd_rd, 5'd0);
        check("stall_first_written", rs1_data, 32'h65);
        @(negedge clk);
        stall = 1'b0;
        tick();
        check("unstall_r_out", bus.r_out, 1'b1);
        check("unstall_no_accept_yet", fwd_rd, 5'd0);
        tick();
        bus.v_in = 1'b0;
        check("unstall_accept", fwd_data, 32'h66);
        tick();
        read1(5'd14);
        check("unstall_written", rs1_data, 32'h66);

        // ---- Reset with a write pending: it must not commit.
        send(enc(OPI, 3'd0, 5'd5), JUNK, 32'h0000_0099, JUNK);
        check("pre_reset_fwd", fwd_rd, 5'd5);
        rst_n = 1'b0;
        read1(5'd5);
        check("midreset_fwd_rd", fwd_rd, 5'd0);
        check("midreset_x5", rs1_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        read1(5'd5);
        check("postreset_x5", rs1_data, 32'd0);
        check("postreset_retired", retired, 64'd0);

        // ---- Ten back-to-back instructions, two of them stores.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.IR = (i == 3 || i == 7) ? enc(STORE, 3'd2, 5'(16 + i)) : enc(OPI, 3'd0, 5'(16 + i));
            bus.A = 32'(i + 1);
            bus.v_in = 1'b1;
        end
        @(negedge clk);
        bus.v_in = 1'b0;
        tick();
        tick();
`ifdef WB_RETIRE_CNT_EN
        exp_ret = 64'd10;
`else
        exp_ret = 64'd0;
`endif
        check("retired_count", retired, exp_ret);
        read1(5'd25);
        check("burst_x25", rs1_data, 32'd10);
        read1(5'd19);
        check("burst_store_x19", rs1_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
